// File: rtl/grayscale_frame_ctrl.sv
// -----------------------------------------------------------------------------
// grayscale_frame_ctrl
//   Sequences one frame of RGB pixels through the grayscale converter datapath.
//   Issues linear reads to the source RGB frame RAM and follows every issued
//   read through the RAM and converter latencies. Each result is written to the
//   destination gray frame RAM at the address it was read from.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse, begins a frame (taken only when idle)
//   pause      in   level, holds off new reads; in-flight pixels still complete
//   abort      in   pulse, stops reading, drains in-flight pixels, no done
//   src_rd_en  out  source RAM read enable
//   src_addr   out  source RAM read address
//   cvt_valid  out  converter input data valid (read enable delayed RD_LAT)
//   dst_wr_en  out  destination RAM write enable (read enable delayed RD_LAT+CVT_LAT)
//   dst_addr   out  destination RAM write address (holds its last value)
//   busy       out  frame in progress (RUN or DRAIN)
//   row_end    out  pulse with the write of the last pixel of each row
//   done       out  one-cycle pulse after the last pixel of a full frame is written
// -----------------------------------------------------------------------------
module grayscale_frame_ctrl #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int ADDR_W  = 19,
   parameter int RD_LAT  = 1,
   parameter int CVT_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
   output logic              src_rd_en,
   output logic [ADDR_W-1:0] src_addr,
   output logic              cvt_valid,
   output logic              dst_wr_en,
   output logic [ADDR_W-1:0] dst_addr,
   output logic              busy,
   output logic              row_end,
   output logic              done
);

   localparam int PIPE_D = RD_LAT + CVT_LAT;
   localparam int X_W    = $clog2(IMG_W);
   localparam int Y_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic              r_aborted;
   logic [PIPE_D-1:0] r_vld;
   logic [PIPE_D-1:0] r_col_last;
   logic [ADDR_W-1:0] r_addr_pipe [PIPE_D];

   logic w_issue;
   logic w_last_pix;
   logic w_pipe_drained;

   // abort has priority over pause and suppresses the read in its own cycle
   assign w_issue    = (r_state == S_RUN) && !pause && !abort;
   assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);
   // Every stage except the output one is empty: the pixel leaving this cycle
   // is the last, so the next state can already signal completion.
   assign w_pipe_drained = (r_vld[PIPE_D-2:0] == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN: begin
            if (abort)                    w_next_state = S_DRAIN;
            else if (!pause && w_last_pix) w_next_state = S_DRAIN;
         end
         S_DRAIN: if (w_pipe_drained) w_next_state = r_aborted ? S_IDLE : S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      src_rd_en = w_issue;
      src_addr  = r_rd_ptr;
      busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
      done      = (r_state == S_DONE);
      cvt_valid = r_vld[RD_LAT-1];
      dst_wr_en = r_vld[PIPE_D-1];
      dst_addr  = r_addr_pipe[PIPE_D-1];
      row_end   = r_vld[PIPE_D-1] && r_col_last[PIPE_D-1];
   end

   // Pixel position and read pointer; the pointer stops on the last pixel so
   // it never leaves the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_rd_ptr <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_x      <= '0;
         r_y      <= '0;
         r_rd_ptr <= '0;
      end else if (w_issue && !w_last_pix) begin
         r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + Y_W'(1);
         end else begin
            r_x <= r_x + X_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                r_aborted <= 1'b0;
      else if ((r_state == S_IDLE) && start)     r_aborted <= 1'b0;
      else if ((r_state == S_RUN) && abort)      r_aborted <= 1'b1;
   end

   // In-flight pixel pipe. An address stage only loads when the stage before
   // it holds a valid pixel, so the output stage keeps the last written address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld      <= '0;
         r_col_last <= '0;
         for (int i = 0; i < PIPE_D; i++) r_addr_pipe[i] <= '0;
      end else begin
         r_vld      <= {r_vld[PIPE_D-2:0], w_issue};
         r_col_last <= {r_col_last[PIPE_D-2:0], (r_x == X_LAST)};
         if (w_issue) r_addr_pipe[0] <= r_rd_ptr;
         for (int i = 1; i < PIPE_D; i++) begin
            if (r_vld[i-1]) r_addr_pipe[i] <= r_addr_pipe[i-1];
         end
      end
   end

endmodule
